alu_issue_ctrl: RTL

Sequential initiator that issues operations to the 4-bit combinational ALU and returns its results. Operation requests arrive on a valid/ready port. The block drives the ALU operand and command lines, holds them stable for a programmable settle window, then captures the result and flags. Results leave on a valid/ready response port. A result accumulator lets a request chain the previous result into operand A.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_settle_cnt.sv | 27 ++
 rtl/alu_issue_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller and its helpers.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned OPW_DEF   = 3;

  localparam logic [2:0] OP_RESERVED = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_settle_cnt.sv
// Loadable down-counter that stops at zero; zero_c flags an expired settle window.
module alu_settle_cnt #(
  parameter int unsigned CW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          zero_c
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time to a combinational ALU, holds its inputs for a
// settle window, then returns the sampled result/flags on a valid/ready port.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned OPW    = OPW_DEF,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OPW-1:0]   req_op,
  input  logic             req_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_com,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] acc
);

  localparam int unsigned CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  state_t state;
  logic   accept;
  logic   reserved;
  logic   cnt_zero_c;

  assign accept   = (state == IDLE) && req_valid && req_ready;
  assign reserved = (req_op == OPW'(OP_RESERVED));

  alu_settle_cnt #(.CW(CW)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && !reserved),
    .en       (state == ISSUE),
    .load_val (CW'(SETTLE - 1)),
    .zero_c   (cnt_zero_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_com   <= '0;
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            if (reserved) begin
              // Reserved command never reaches the ALU; answer immediately.
              rsp_r     <= '0;
              rsp_carry <= 1'b0;
              rsp_zero  <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_a   <= req_use_acc ? acc : req_a;
              alu_b   <= req_b;
              alu_com <= req_op;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (cnt_zero_c) begin
            rsp_r     <= alu_r;
            rsp_carry <= alu_carry;
            rsp_zero  <= alu_zero;
            rsp_err   <= 1'b0;
            acc       <= alu_r;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
